// File: rtl/pll_reset_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pll_reset_pkg
// Desc   : State encoding, default phase lengths and output decode shared by
//          the PLL reset/lock sequencer.
// Rev    : 1.0 - initial release
// ============================================================================
package pll_reset_pkg;

    typedef enum logic [2:0] {
        ST_PLLRST    = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_FILTER    = 3'd2,
        ST_HOLD_MEM  = 3'd3,
        ST_HOLD_SYS  = 3'd4,
        ST_RUN       = 3'd5
    } state_t;

    localparam int c_def_sync_stages    = 2;
    localparam int c_def_pll_rst_cycles = 16;
    localparam int c_def_lock_timeout   = 50000;
    localparam int c_def_lock_filter    = 1024;
    localparam int c_def_mem_delay      = 256;
    localparam int c_def_sys_delay      = 64;
    localparam int c_def_cnt_w          = 16;
    localparam int c_relock_w           = 8;

    typedef struct packed {
        logic pll_rst;
        logic mem_rst;
        logic sys_rst;
        logic ready;
    } rst_outs_t;

    function automatic rst_outs_t decode_outputs(input state_t st);
        rst_outs_t o;
        o = '{pll_rst: 1'b0, mem_rst: 1'b1, sys_rst: 1'b1, ready: 1'b0};
        case (st)
            ST_PLLRST:   o.pll_rst = 1'b1;
            ST_HOLD_SYS: o.mem_rst = 1'b0;
            ST_RUN: begin
                o.mem_rst = 1'b0;
                o.sys_rst = 1'b0;
                o.ready   = 1'b1;
            end
            default: ;
        endcase
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bit_sync.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : bit_sync
// Desc   : N-stage single-bit synchronizer, asynchronously cleared to 0.
// Rev    : 1.0 - initial release
// ============================================================================
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    if (STAGES < 2) begin : g_bad_stages
        $error("bit_sync: STAGES must be at least 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/pll_reset_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : pll_reset_sequencer
// Desc   : Pulses PLL reset, filters lock, then releases memory and SoC resets
//          in order; re-arms on lock loss and counts relock events.
// Rev    : 1.0 - initial release
// ============================================================================
module pll_reset_sequencer
    import pll_reset_pkg::*;
#(
    parameter int SYNC_STAGES    = c_def_sync_stages,
    parameter int PLL_RST_CYCLES = c_def_pll_rst_cycles,
    parameter int LOCK_TIMEOUT   = c_def_lock_timeout,
    parameter int LOCK_FILTER    = c_def_lock_filter,
    parameter int MEM_DELAY      = c_def_mem_delay,
    parameter int SYS_DELAY      = c_def_sys_delay,
    parameter int CNT_W          = c_def_cnt_w
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  locked,
    output logic                  pll_rst,
    output logic                  mem_rst,
    output logic                  sys_rst,
    output logic                  ready,
    output logic [c_relock_w-1:0] relock_count
);

    localparam longint c_cnt_span = longint'(1) << CNT_W;

    if (SYNC_STAGES < 2 ||
        PLL_RST_CYCLES < 1 || longint'(PLL_RST_CYCLES) >= c_cnt_span ||
        LOCK_TIMEOUT   < 1 || longint'(LOCK_TIMEOUT)   >= c_cnt_span ||
        LOCK_FILTER    < 1 || longint'(LOCK_FILTER)    >= c_cnt_span ||
        MEM_DELAY      < 1 || longint'(MEM_DELAY)      >= c_cnt_span ||
        SYS_DELAY      < 1 || longint'(SYS_DELAY)      >= c_cnt_span) begin : g_bad_params
        $error("pll_reset_sequencer: cycle parameter out of range for CNT_W");
    end

    localparam logic [CNT_W-1:0] c_pll_last  = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_tmo_last  = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] c_filt_last = CNT_W'(LOCK_FILTER - 1);
    localparam logic [CNT_W-1:0] c_mem_last  = CNT_W'(MEM_DELAY - 1);
    localparam logic [CNT_W-1:0] c_sys_last  = CNT_W'(SYS_DELAY - 1);

    logic                  w_lock_s;
    state_t                r_state;
    state_t                w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    rst_outs_t             w_outs_nxt;
    logic                  w_relock_evt;
    logic                  r_pll_rst;
    logic                  r_mem_rst;
    logic                  r_sys_rst;
    logic                  r_ready;
    logic [c_relock_w-1:0] r_relock;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .i_d (locked),
        .o_q (w_lock_s)
    );

    // Lock loss is tested before any counter expiry so it always wins.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_PLLRST: begin
                if (r_cnt == c_pll_last) w_state_nxt = ST_WAIT_LOCK;
            end
            ST_WAIT_LOCK: begin
                if (w_lock_s)                 w_state_nxt = ST_FILTER;
                else if (r_cnt == c_tmo_last) w_state_nxt = ST_PLLRST;
            end
            ST_FILTER: begin
                if (!w_lock_s)                 w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == c_filt_last) w_state_nxt = ST_HOLD_MEM;
            end
            ST_HOLD_MEM: begin
                if (!w_lock_s)                w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == c_mem_last) w_state_nxt = ST_HOLD_SYS;
            end
            ST_HOLD_SYS: begin
                if (!w_lock_s)                w_state_nxt = ST_WAIT_LOCK;
                else if (r_cnt == c_sys_last) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (!w_lock_s) w_state_nxt = ST_WAIT_LOCK;
            end
            default: w_state_nxt = ST_PLLRST;
        endcase
    end

    assign w_outs_nxt   = decode_outputs(w_state_nxt);
    assign w_relock_evt = (r_state == ST_RUN) && (w_state_nxt == ST_WAIT_LOCK);

    // Outputs are registered from the next state so they always match r_state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_PLLRST;
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            r_mem_rst <= 1'b1;
            r_sys_rst <= 1'b1;
            r_ready   <= 1'b0;
            r_relock  <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= (w_state_nxt != r_state) ? '0 : r_cnt + 1'b1;
            r_pll_rst <= w_outs_nxt.pll_rst;
            r_mem_rst <= w_outs_nxt.mem_rst;
            r_sys_rst <= w_outs_nxt.sys_rst;
            r_ready   <= w_outs_nxt.ready;
            if (w_relock_evt && (r_relock != '1)) begin
                r_relock <= r_relock + 1'b1;
            end
        end
    end

    assign pll_rst      = r_pll_rst;
    assign mem_rst      = r_mem_rst;
    assign sys_rst      = r_sys_rst;
    assign ready        = r_ready;
    assign relock_count = r_relock;

endmodule
`default_nettype wire
